// File: rtl/sphere_contact_fifo.sv
// Contact-record FIFO behind the sphere-sphere collider: captures one record per rising
// edge of done, queues contacts (ret=1) and hands them downstream over valid/ready.
module sphere_contact_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic              ret,
    input  logic [31:0]       cx,
    input  logic [31:0]       cy,
    input  logic [31:0]       cz,
    input  logic [31:0]       normalx,
    input  logic [31:0]       normaly,
    input  logic [31:0]       normalz,
    input  logic [31:0]       depth,
    input  logic [31:0]       g1,
    input  logic [31:0]       g2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_cx,
    output logic [31:0]       out_cy,
    output logic [31:0]       out_cz,
    output logic [31:0]       out_normalx,
    output logic [31:0]       out_normaly,
    output logic [31:0]       out_normalz,
    output logic [31:0]       out_depth,
    output logic [31:0]       out_g1,
    output logic [31:0]       out_g2,
    output logic [AW:0]       count,
    output logic              full,
    output logic [15:0]       pair_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int          RW       = 9 * 32;
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ZERO = {(AW + 1){1'b0}};
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW - 1){1'b0}}, 1'b1};

    logic [RW-1:0] mem_r [DEPTH];
    logic          done_q_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW:0]   count_r;
    logic [15:0]   pair_cnt_r;
    logic [15:0]   drop_cnt_r;

    logic          cap_s;
    logic          push_s;
    logic          pop_s;
    logic          full_s;
    logic          accept_s;
    logic          drop_s;
    logic [AW:0]   count_nxt_s;
    logic [RW-1:0] wr_data_s;

    // Edge detect, handshake decode and occupancy update.
    always_comb begin
        cap_s       = done & ~done_q_r;
        push_s      = cap_s & ret;
        pop_s       = (count_r != CNT_ZERO) & out_ready;
        full_s      = (count_r == DEPTH_C);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        accept_s    = push_s & (~full_s | pop_s);
        drop_s      = push_s & full_s & ~pop_s;
        wr_data_s   = {cx, cy, cz, normalx, normaly, normalz, depth, g1, g2};
        count_nxt_s = count_r;
        case ({accept_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Control state: pointers, occupancy, edge history and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q_r   <= 1'b0;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= CNT_ZERO;
            pair_cnt_r <= 16'h0000;
            drop_cnt_r <= 16'h0000;
        end else begin
            done_q_r <= done;
            count_r  <= count_nxt_s;
            if (cap_s) begin
                pair_cnt_r <= pair_cnt_r + 16'h0001;
            end
            if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'h0001;
            end
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Record storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= wr_data_s;
        end
    end

    assign out_valid = (count_r != CNT_ZERO);
    assign full      = full_s;
    assign count     = count_r;
    assign pair_cnt  = pair_cnt_r;
    assign drop_cnt  = drop_cnt_r;
    assign {out_cx, out_cy, out_cz, out_normalx, out_normaly, out_normalz,
            out_depth, out_g1, out_g2} = mem_r[rd_ptr_r];

endmodule
